// File: rtl/dmem_pkg.sv
// dmem_pkg: access-size and FSM enums plus lane helpers shared by the data-memory responder.
package dmem_pkg;
  typedef enum logic [1:0] {SZ_B = 2'b00, SZ_H = 2'b01, SZ_W = 2'b10} size_e;
  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_e;
  function automatic size_e norm_size(input logic [1:0] s);
    return s == 2'b11 ? SZ_W : size_e'(s);
  endfunction
  function automatic logic [1:0] align_off(input size_e sz, input logic [1:0] off);
    return sz == SZ_W ? 2'b00 : sz == SZ_H ? {off[1], 1'b0} : off;
  endfunction
  function automatic logic [3:0] byte_en(input size_e sz, input logic [1:0] off);
    return sz == SZ_W ? 4'hf : sz == SZ_H ? 4'b0011 << off : 4'b0001 << off;
  endfunction
  function automatic logic misaligned(input size_e sz, input logic [1:0] off);
    return sz == SZ_W ? |off : sz == SZ_H && off[0];
  endfunction
endpackage

// File: rtl/dmem_load_align.sv
// dmem_load_align: lane select and sign/zero extension of a loaded word.
module dmem_load_align
  import dmem_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  off,
  input  size_e       sz,
  input  logic        uns,
  output logic [31:0] data
);
  logic [31:0] sh;
  assign sh = word >> {off, 3'b000};
  assign data = sz == SZ_B ? {{24{~uns & sh[7]}}, sh[7:0]} :
                sz == SZ_H ? {{16{~uns & sh[15]}}, sh[15:0]} : sh;
endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: valid/ready load/store responder over a word RAM with fixed wait states; DMEM_MISALIGN_ERR_EN flags misaligned accesses.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic                  req_we,
  input  logic [1:0]            req_size,
  input  logic                  req_unsigned,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err
);
  localparam int IW = $clog2(DEPTH_WORDS);
  state_e state;
  logic [3:0] cnt;
  logic [IW-1:0] c_idx, a_idx;
  logic [1:0] c_off, a_off, r_off;
  size_e c_sz, a_sz, r_sz;
  logic c_we, a_we, c_uns, a_uns, a_mis, accept, acc, unused_addr;
  logic [DATA_WIDTH-1:0] c_wdata, a_wdata, wsh, ld;
  logic [3:0] be;
  logic [DATA_WIDTH-1:0] mem [DEPTH_WORDS];
  assign req_ready = state == ST_IDLE;
  assign rsp_valid = state == ST_RESP;
  assign accept = req_ready && req_valid;
  assign unused_addr = ^req_addr;
  assign r_sz = norm_size(req_size);
  assign r_off = align_off(r_sz, req_addr[1:0]);
  // With zero wait states the access happens on the capture edge, so use the live request
  assign a_idx = req_ready ? req_addr[IW+1:2] : c_idx;
  assign a_off = req_ready ? r_off : c_off;
  assign a_sz = req_ready ? r_sz : c_sz;
  assign a_we = req_ready ? req_we : c_we;
  assign a_uns = req_ready ? req_unsigned : c_uns;
  assign a_wdata = req_ready ? req_wdata : c_wdata;
`ifdef DMEM_MISALIGN_ERR_EN
  logic c_mis;
  assign a_mis = req_ready ? misaligned(r_sz, req_addr[1:0]) : c_mis;
`else
  assign a_mis = 1'b0;
  assign rsp_err = 1'b0;
`endif
  assign acc = !rst && (WAIT_CYCLES == 0 ? accept : state == ST_WAIT && cnt == 4'd1);
  assign be = byte_en(a_sz, a_off);
  assign wsh = a_wdata << {a_off, 3'b000};
  dmem_load_align u_align (
    .word(mem[a_idx]),
    .off (a_off),
    .sz  (a_sz),
    .uns (a_uns),
    .data(ld)
  );
  always_ff @(posedge clk)
    if (acc && a_we && !a_mis)
      for (int i = 0; i < 4; i++)
        if (be[i]) mem[a_idx][8*i+:8] <= wsh[8*i+:8];
  always_ff @(posedge clk)
    if (rst) begin
      state <= ST_IDLE;
      cnt <= '0;
      rsp_rdata <= '0;
`ifdef DMEM_MISALIGN_ERR_EN
      rsp_err <= 1'b0;
`endif
    end else begin
      if (accept) begin
        c_idx <= req_addr[IW+1:2];
        c_off <= r_off;
        c_sz <= r_sz;
        c_we <= req_we;
        c_uns <= req_unsigned;
        c_wdata <= req_wdata;
`ifdef DMEM_MISALIGN_ERR_EN
        c_mis <= misaligned(r_sz, req_addr[1:0]);
`endif
        cnt <= 4'(WAIT_CYCLES);
        state <= WAIT_CYCLES == 0 ? ST_RESP : ST_WAIT;
      end
      if (state == ST_WAIT) begin
        cnt <= cnt - 4'd1;
        if (cnt == 4'd1) state <= ST_RESP;
      end
      if (state == ST_RESP && rsp_ready) state <= ST_IDLE;
      if (acc) begin
        rsp_rdata <= (a_we || a_mis) ? '0 : ld;
`ifdef DMEM_MISALIGN_ERR_EN
        rsp_err <= a_mis;
`endif
      end
    end
endmodule
